// File: rtl/fpu_ss_scoreboard.sv
// fpu_ss_scoreboard: dependency and commit scoreboard between the FPU input buffer and dispatch.
// Latency: issue_stall_o/fwd_* are combinational; pending_o, mem_out_cnt_o and idle_o reflect state one cycle after the event.
// Backpressure: issue_stall_o holds the candidate until RAW, WAW, ID-commit and memory-credit conditions clear.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   issue_*                    candidate instruction (operands, destination, offload ID) and dispatch strobe
//   issue_stall_o, fwd_*       dispatch hold and per-operand write-back forwarding select
//   commit_*                   offload commit/kill from the core
//   wb_valid_i, wb_rd_i        NUM_WB write-back channels into the FP register file
//   mem_done_i                 one outstanding memory request retired
//   pending_o, mem_out_cnt_o, idle_o, err_o   state views
//
// Build option: define FPU_SS_SCOREBOARD_ERR_EN to make err_o a sticky counter
// underflow/overflow flag. Without it, err_o is tied low; counters still clamp.

module fpu_ss_scoreboard #(
  parameter int unsigned NUM_WB      = 2,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned CNT_WIDTH   = 2,
  parameter int unsigned MAX_MEM_OUT = 4,
  parameter bit          FORWARDING  = 1'b1,
  localparam int unsigned SRC_W      = (NUM_WB > 1) ? $clog2(NUM_WB) : 1,
  localparam int unsigned MEM_W      = $clog2(MAX_MEM_OUT + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  input  logic [2:0][4:0]            issue_rs_i,
  input  logic [2:0]                 issue_rs_used_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       issue_rd_fp_i,
  input  logic                       issue_is_mem_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  input  logic                       issue_fire_i,
  output logic                       issue_stall_o,
  output logic [2:0]                 fwd_valid_o,
  output logic [2:0][SRC_W-1:0]      fwd_src_o,
  input  logic                       commit_valid_i,
  input  logic                       commit_kill_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic [NUM_WB-1:0]          wb_valid_i,
  input  logic [NUM_WB-1:0][4:0]     wb_rd_i,
  input  logic                       mem_done_i,
  output logic [31:0]                pending_o,
  output logic [MEM_W-1:0]           mem_out_cnt_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MEM_W-1:0]     MEM_MAX = MEM_W'(MAX_MEM_OUT);
  localparam int unsigned          NUM_ID  = 1 << ID_WIDTH;

  // ---------------------------------------------------------------------------
  // Per-register pending-write counters
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q [32];
  logic [CNT_WIDTH-1:0] cnt_d [32];
  logic [31:0]          wb_hit;     // some channel writes register r this cycle
  logic                 cnt_err;

  always_comb begin
    int sum;
    sum     = 0;
    cnt_err = 1'b0;
    wb_hit  = '0;
    cnt_d   = cnt_q;
    for (int r = 0; r < 32; r++) begin
      sum = int'(cnt_q[r]);
      if (issue_fire_i && issue_rd_fp_i && (issue_rd_i == 5'(r))) sum = sum + 1;
      for (int c = 0; c < int'(NUM_WB); c++) begin
        if (wb_valid_i[c] && (wb_rd_i[c] == 5'(r))) begin
          sum       = sum - 1;
          wb_hit[r] = 1'b1;
        end
      end
      // Clamp into the counter range; either excursion is a protocol error.
      if (sum < 0) begin
        cnt_d[r] = '0;
        cnt_err  = 1'b1;
      end else if (sum > int'(CNT_MAX)) begin
        cnt_d[r] = CNT_MAX;
        cnt_err  = 1'b1;
      end else begin
        cnt_d[r] = CNT_WIDTH'(sum);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) pending_o[r] = (cnt_q[r] != '0);
  end

  // ---------------------------------------------------------------------------
  // RAW check and forwarding. Forwarding only resolves a dependency on the
  // last outstanding write (count of one); the lowest matching channel wins.
  // ---------------------------------------------------------------------------
  logic raw_block;

  always_comb begin
    logic                 dep;
    logic                 hit;
    logic                 fwd;
    logic [SRC_W-1:0]     src;
    dep         = 1'b0;
    hit         = 1'b0;
    fwd         = 1'b0;
    src         = '0;
    raw_block   = 1'b0;
    fwd_valid_o = '0;
    fwd_src_o   = '0;
    for (int i = 0; i < 3; i++) begin
      dep = issue_rs_used_i[i] && (cnt_q[issue_rs_i[i]] != '0);
      hit = 1'b0;
      src = '0;
      // Descending scan so the lowest-index match is the one left standing.
      for (int c = int'(NUM_WB) - 1; c >= 0; c--) begin
        if (wb_valid_i[c] && (wb_rd_i[c] == issue_rs_i[i])) begin
          hit = 1'b1;
          src = SRC_W'(c);
        end
      end
      fwd = FORWARDING && (cnt_q[issue_rs_i[i]] == CNT_WIDTH'(1)) && hit;
      if (dep && fwd) begin
        fwd_valid_o[i] = issue_valid_i;
        fwd_src_o[i]   = src;
      end
      if (dep && !fwd) raw_block = 1'b1;
    end
  end

  // WAW: destination counter full, unless a write-back frees a slot now.
  logic waw_block;
  assign waw_block = issue_rd_fp_i && (cnt_q[issue_rd_i] == CNT_MAX) && !wb_hit[issue_rd_i];

  // ---------------------------------------------------------------------------
  // Committed offload IDs
  // ---------------------------------------------------------------------------
  logic [NUM_ID-1:0] id_q;
  logic              commit_set;
  logic              id_ready;

  assign commit_set = commit_valid_i && !commit_kill_i;
  assign id_ready   = id_q[issue_id_i] || (commit_set && (commit_id_i == issue_id_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= '0;
    end else begin
      if (commit_set)   id_q[commit_id_i] <= 1'b1;
      // Later assignment wins: dispatch consumes the commit of the same ID.
      if (issue_fire_i) id_q[issue_id_i]  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding memory requests
  // ---------------------------------------------------------------------------
  logic [MEM_W-1:0] mem_q;
  logic [MEM_W-1:0] mem_d;
  logic             mem_inc;
  logic             mem_err;
  logic             mem_block;

  assign mem_inc   = issue_fire_i && issue_is_mem_i;
  assign mem_block = issue_is_mem_i && (mem_q == MEM_MAX) && !mem_done_i;

  always_comb begin
    mem_d   = mem_q;
    mem_err = 1'b0;
    if (mem_inc && !mem_done_i) begin
      if (mem_q == MEM_MAX) mem_err = 1'b1;
      else                  mem_d   = mem_q + MEM_W'(1);
    end else if (!mem_inc && mem_done_i) begin
      if (mem_q == '0) mem_err = 1'b1;
      else             mem_d   = mem_q - MEM_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '0;
    else         mem_q <= mem_d;
  end

  assign mem_out_cnt_o = mem_q;
  assign idle_o        = (pending_o == '0) && (mem_q == '0);

  // ---------------------------------------------------------------------------
  // Dispatch hold
  // ---------------------------------------------------------------------------
  assign issue_stall_o = issue_valid_i && (raw_block || waw_block || !id_ready || mem_block);

  // ---------------------------------------------------------------------------
  // Error flag
  // ---------------------------------------------------------------------------
`ifdef FPU_SS_SCOREBOARD_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  err_q <= 1'b0;
    else if (cnt_err || mem_err)  err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_err_flags;
  assign unused_err_flags = cnt_err | mem_err;
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_ss_scoreboard.sv
// Scoreboard bench for fpu_ss_scoreboard: directed corner sequences followed by random traffic,
// expected outputs from an array/queue reference model, compared by an independent monitor.
// Inputs driven on the falling edge, outputs sampled 2 time units later.

module tb_fpu_ss_scoreboard;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i;
  logic [2:0][4:0]   issue_rs_i;
  logic [2:0]        issue_rs_used_i;
  logic [4:0]        issue_rd_i;
  logic              issue_rd_fp_i;
  logic              issue_is_mem_i;
  logic [3:0]        issue_id_i;
  logic              issue_fire_i;
  logic              issue_stall_o;
  logic [2:0]        fwd_valid_o;
  logic [2:0][0:0]   fwd_src_o;
  logic              commit_valid_i;
  logic              commit_kill_i;
  logic [3:0]        commit_id_i;
  logic [1:0]        wb_valid_i;
  logic [1:0][4:0]   wb_rd_i;
  logic              mem_done_i;
  logic [31:0]       pending_o;
  logic [2:0]        mem_out_cnt_o;
  logic              idle_o;
  logic              err_o;

  fpu_ss_scoreboard #(
    .NUM_WB(2), .ID_WIDTH(4), .CNT_WIDTH(2), .MAX_MEM_OUT(4), .FORWARDING(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_rs_i(issue_rs_i), .issue_rs_used_i(issue_rs_used_i),
    .issue_rd_i(issue_rd_i), .issue_rd_fp_i(issue_rd_fp_i), .issue_is_mem_i(issue_is_mem_i),
    .issue_id_i(issue_id_i), .issue_fire_i(issue_fire_i), .issue_stall_o(issue_stall_o),
    .fwd_valid_o(fwd_valid_o), .fwd_src_o(fwd_src_o),
    .commit_valid_i(commit_valid_i), .commit_kill_i(commit_kill_i), .commit_id_i(commit_id_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .mem_done_i(mem_done_i),
    .pending_o(pending_o), .mem_out_cnt_o(mem_out_cnt_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef FPU_SS_SCOREBOARD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit            valid;
    bit [2:0][4:0] rs;
    bit [2:0]      used;
    bit [4:0]      rd;
    bit            rd_fp;
    bit            is_mem;
    bit [3:0]      id;
    bit            want_fire;
    bit            cv;
    bit            ck;
    bit [3:0]      cid;
    bit [1:0]      wbv;
    bit [1:0][4:0] wbrd;
    bit            done;
  } stim_t;

  typedef struct {
    bit          stall;
    bit [2:0]    fv;
    bit [2:0]    fs;
    bit [31:0]   pend;
    int unsigned mem;
    bit          idle;
    bit          err;
  } exp_t;

  // Reference model state: plain counts, a set of committed IDs, a request count.
  int    m_cnt [32];
  bit    m_ids [16];
  int    m_mem;
  bit    m_err;
  exp_t  exp_q [$];

  int vectors    = 0;
  int miscompares = 0;

  function automatic stim_t blank();
    stim_t s;
    s.valid = 0; s.rs = '0; s.used = '0; s.rd = '0; s.rd_fp = 0; s.is_mem = 0;
    s.id = '0; s.want_fire = 0; s.cv = 0; s.ck = 0; s.cid = '0; s.wbv = '0;
    s.wbrd = '0; s.done = 0;
    return s;
  endfunction

  // Candidate whose ID commits in the same cycle, so only the other hazards matter.
  function automatic stim_t iss(input int id);
    stim_t s;
    s = blank();
    s.valid = 1; s.id = 4'(id); s.cv = 1; s.cid = 4'(id); s.want_fire = 1;
    return s;
  endfunction

  function automatic exp_t state_view();
    exp_t e;
    e.stall = 0; e.fv = '0; e.fs = '0;
    for (int r = 0; r < 32; r++) e.pend[r] = (m_cnt[r] != 0);
    e.mem  = m_mem;
    e.idle = (e.pend == 0) && (m_mem == 0);
    e.err  = ERR_EN && m_err;
    return e;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    for (int i = 0; i < 16; i++) m_ids[i] = 0;
    m_mem = 0;
    m_err = 0;
  endtask

  task automatic drive_idle();
    issue_valid_i = 0; issue_rs_i = '0; issue_rs_used_i = '0; issue_rd_i = '0;
    issue_rd_fp_i = 0; issue_is_mem_i = 0; issue_id_i = '0; issue_fire_i = 0;
    commit_valid_i = 0; commit_kill_i = 0; commit_id_i = '0;
    wb_valid_i = '0; wb_rd_i = '0; mem_done_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0;
    drive_idle();
    model_reset();
    exp_q.push_back(state_view());
  endtask

  task automatic tick(input stim_t s);
    exp_t e;
    bit   blocked, waw, rd_wb, id_ok, mem_blk, fire;
    int   found, n, wbs;
    @(negedge clk_i);
    rst_ni = 1;
    e = state_view();
    blocked = 0;
    for (int i = 0; i < 3; i++) begin
      if (s.used[i] && m_cnt[s.rs[i]] > 0) begin
        found = -1;
        for (int c = 0; c < 2; c++)
          if (found < 0 && s.wbv[c] && s.wbrd[c] == s.rs[i]) found = c;
        if (m_cnt[s.rs[i]] == 1 && found >= 0) begin
          e.fv[i] = s.valid;
          e.fs[i] = (found == 1);
        end else begin
          blocked = 1;
        end
      end
    end
    rd_wb = 0;
    for (int c = 0; c < 2; c++) if (s.wbv[c] && s.wbrd[c] == s.rd) rd_wb = 1;
    waw     = s.rd_fp && m_cnt[s.rd] == 3 && !rd_wb;
    id_ok   = m_ids[s.id] || (s.cv && !s.ck && s.cid == s.id);
    mem_blk = s.is_mem && m_mem == 4 && !s.done;
    e.stall = s.valid && (blocked || waw || !id_ok || mem_blk);
    fire    = s.valid && !e.stall && s.want_fire;
    exp_q.push_back(e);

    issue_valid_i = s.valid; issue_rs_i = s.rs; issue_rs_used_i = s.used;
    issue_rd_i = s.rd; issue_rd_fp_i = s.rd_fp; issue_is_mem_i = s.is_mem;
    issue_id_i = s.id; issue_fire_i = fire;
    commit_valid_i = s.cv; commit_kill_i = s.ck; commit_id_i = s.cid;
    wb_valid_i = s.wbv; wb_rd_i = s.wbrd; mem_done_i = s.done;

    // Advance the model to the state seen after the coming rising edge.
    for (int r = 0; r < 32; r++) begin
      wbs = 0;
      for (int c = 0; c < 2; c++) if (s.wbv[c] && s.wbrd[c] == r) wbs++;
      n = m_cnt[r] + ((fire && s.rd_fp && s.rd == r) ? 1 : 0) - wbs;
      if (n < 0) begin n = 0; m_err = 1; end
      if (n > 3) begin n = 3; m_err = 1; end
      m_cnt[r] = n;
    end
    if (s.cv && !s.ck) m_ids[s.cid] = 1;
    if (fire) m_ids[s.id] = 0;
    n = m_mem + ((fire && s.is_mem) ? 1 : 0) - (s.done ? 1 : 0);
    if (n < 0) begin n = 0; m_err = 1; end
    if (n > 4) begin n = 4; m_err = 1; end
    m_mem = n;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle the driver has issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_stall", 32'(issue_stall_o), 32'(e.stall));
        for (int i = 0; i < 3; i++) begin
          check("fwd_valid", 32'(fwd_valid_o[i]), 32'(e.fv[i]));
          if (e.fv[i]) check("fwd_src", 32'(fwd_src_o[i]), 32'(e.fs[i]));
        end
        check("pending", pending_o, e.pend);
        check("mem_out_cnt", 32'(mem_out_cnt_o), e.mem);
        check("idle", 32'(idle_o), 32'(e.idle));
        check("err", 32'(err_o), 32'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    int    r;
    drive_idle();
    do_reset();

    // Independent reader with same-cycle commit of its ID.
    s = iss(2); s.rs[0] = 5'd3; s.used = 3'b001; s.want_fire = 0; tick(s);

    // Two writes to f5, reader blocked at count 2, forwarded from channel 1 at count 1.
    for (int k = 0; k < 2; k++) begin s = iss(k); s.rd = 5'd5; s.rd_fp = 1; tick(s); end
    s = iss(3); s.rs[0] = 5'd5; s.used = 3'b001; s.want_fire = 0;
    s.wbv = 2'b10; s.wbrd[1] = 5'd5;
    tick(s);
    tick(s);

    // f7: dual write-back drains count 2, then dual-channel forward picks channel 0.
    for (int k = 5; k < 7; k++) begin s = iss(k); s.rd = 5'd7; s.rd_fp = 1; tick(s); end
    s = blank(); s.wbv = 2'b11; s.wbrd[0] = 5'd7; s.wbrd[1] = 5'd7; tick(s);
    s = iss(7); s.rd = 5'd7; s.rd_fp = 1; tick(s);
    s = iss(12); s.rs[1] = 5'd7; s.used = 3'b010; s.want_fire = 0;
    s.wbv = 2'b11; s.wbrd[0] = 5'd7; s.wbrd[1] = 5'd7;
    tick(s);

    // f9: counter full, WAW stall, relieved by a same-cycle write-back.
    for (int k = 8; k < 11; k++) begin s = iss(k); s.rd = 5'd9; s.rd_fp = 1; tick(s); end
    s = iss(11); s.rd = 5'd9; s.rd_fp = 1; tick(s);
    s.wbv = 2'b01; s.wbrd[0] = 5'd9; tick(s);
    s = blank(); tick(s);

    // ID 4: killed commit does not ready it; live commit bypasses; fire clears it.
    s = blank(); s.cv = 1; s.ck = 1; s.cid = 4'd4; tick(s);
    s = iss(4); s.cv = 0; tick(s);
    s = iss(4); tick(s);
    s = iss(4); s.cv = 0; tick(s);

    // Memory credits.
    do_reset();
    for (int k = 0; k < 4; k++) begin s = iss(k); s.is_mem = 1; tick(s); end
    s = iss(4); s.is_mem = 1; tick(s);
    s.done = 1; tick(s);
    s = iss(5); s.is_mem = 1; s.done = 1; tick(s);
    s = blank(); s.done = 1;
    for (int k = 0; k < 4; k++) tick(s);
    tick(s);
    s = blank(); tick(s);

    // Random traffic on a small register window to provoke hazards.
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) do_reset();
      s = blank();
      s.valid = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 3; i++) s.rs[i] = 5'($urandom_range(0, 5));
      s.used      = 3'($urandom_range(0, 7));
      s.rd        = 5'($urandom_range(0, 5));
      s.rd_fp     = ($urandom_range(0, 3) != 0);
      s.is_mem    = ($urandom_range(0, 2) == 0);
      s.id        = 4'($urandom_range(0, 15));
      s.want_fire = ($urandom_range(0, 3) != 0);
      s.cv        = ($urandom_range(0, 1) == 1);
      s.ck        = ($urandom_range(0, 3) == 0);
      s.cid       = ($urandom_range(0, 1) == 1) ? s.id : 4'($urandom_range(0, 15));
      for (int c = 0; c < 2; c++) begin
        r = $urandom_range(0, 5);
        s.wbrd[c] = 5'(r);
        s.wbv[c]  = ($urandom_range(0, 2) == 0) && (m_cnt[r] > 0 || $urandom_range(0, 40) == 0);
      end
      s.done = (m_mem > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      tick(s);
    end

    s = blank();
    tick(s);
    repeat (3) @(negedge clk_i);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
